// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the CPU control sequencer (master)
// and the memory responder (slave).
interface mem_responder_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] mar_addr;
   logic [DATA_W-1:0] wdata;
   logic              mdr_read;
   logic              ram_write;
   logic [DATA_W-1:0] rdata;
   logic              mem_ready;
   logic              busy;
   logic              overrun;
   modport master (
      output mar_addr, wdata, mdr_read, ram_write,
      input  rdata, mem_ready, busy, overrun
   );
   modport slave (
      input  mar_addr, wdata, mdr_read, ram_write,
      output rdata, mem_ready, busy, overrun
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM with programmable wait states and a one-cycle ready pulse.
// Define MEM_RANGE_CHECK_EN to trap addresses >= DEPTH (all-ones reads, no writes) instead of wrapping.
module mem_responder #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 9,
   parameter int DEPTH       = 512,
   parameter int WAIT_CYCLES = 2
) (
   input logic            clk,
   input logic            rst_n,
   mem_responder_if.slave bus
);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic [3:0]        cnt;
   logic              op_wr, prev_rd, prev_wr, rd_edge, wr_edge, accept, done, oor;
   logic [IW-1:0]     idx;
   assign rd_edge = bus.mdr_read & ~prev_rd;
   assign wr_edge = bus.ram_write & ~prev_wr;
   // A fresh edge is taken in IDLE and also in the RESP cycle, giving back-to-back service.
   assign accept  = state != S_WAIT && (rd_edge || wr_edge);
   assign done    = state == S_WAIT && cnt == 4'd0;
   assign idx     = IW'(32'(addr) % DEPTH);
`ifdef MEM_RANGE_CHECK_EN
   assign oor = 32'(addr) >= DEPTH;
`else
   assign oor = 1'b0;
`endif
   // Array is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk)
      if (done && op_wr && !oor) mem[idx] <= data;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= 4'd0;
         addr          <= '0;
         data          <= '0;
         op_wr         <= 1'b0;
         prev_rd       <= 1'b0;
         prev_wr       <= 1'b0;
         bus.rdata     <= '0;
         bus.mem_ready <= 1'b0;
         bus.busy      <= 1'b0;
         bus.overrun   <= 1'b0;
      end else begin
         prev_rd       <= bus.mdr_read;
         prev_wr       <= bus.ram_write;
         bus.mem_ready <= 1'b0;
         if (accept) begin
            state    <= S_WAIT;
            cnt      <= 4'(WAIT_CYCLES);
            addr     <= bus.mar_addr;
            data     <= bus.wdata;
            op_wr    <= wr_edge;
            bus.busy <= 1'b1;
            if (rd_edge && wr_edge) bus.overrun <= 1'b1;
         end else if (state == S_RESP) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
         end else if (state == S_WAIT) begin
            if (rd_edge || wr_edge) bus.overrun <= 1'b1;
            if (done) begin
               state         <= S_RESP;
               bus.mem_ready <= 1'b1;
               if (!op_wr) bus.rdata <= oor ? '1 : mem[idx];
               if (oor) bus.overrun <= 1'b1;
            end else begin
               cnt <= cnt - 4'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder against a queue/array reference model.
module tb_mem_responder;
   localparam int W     = 2;
   localparam int DEPTH = 256;
   localparam int AW    = 9;
   typedef struct {
      logic [31:0] rdata;
      logic        ovr;
      int          cyc;
   } exp_t;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc   = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          bc    = 0;
   exp_t        q[$];
   exp_t        e;
   logic [31:0] mem_m [DEPTH];
   logic [31:0] last_rd = '0;
   logic        ovr_m   = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mem_responder_if #(.ADDR_W(AW), .DATA_W(32)) bus ();
   mem_responder #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Reference: serialized accesses, each completing W+1 cycles after acceptance.
   function automatic void model(bit rd, bit wr, logic [AW-1:0] a, logic [31:0] d, int n, bit inj);
      int   i   = int'(a) % DEPTH;
      bit   oor = 1'b0;
      exp_t x;
`ifdef MEM_RANGE_CHECK_EN
      oor = int'(a) >= DEPTH;
`endif
      if ((rd && wr) || inj || oor) ovr_m = 1'b1;
      if (wr) begin
         if (!oor) mem_m[i] = d;
      end else begin
         last_rd = oor ? '1 : mem_m[i];
      end
      x.rdata = last_rd;
      x.ovr   = ovr_m;
      x.cyc   = n + W + 1;
      q.push_back(x);
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.mem_ready) begin
         if (q.size() == 0) chk("spurious_ready", 1, 0);
         else begin
            e = q.pop_front();
            chk("rdata", bus.rdata, e.rdata);
            chk("overrun", bus.overrun, e.ovr);
            chk("ready_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      bc += int'(bus.busy);
   endtask

   // Called just after a falling edge; the request is sampled at the next rising edge.
   task automatic txn(bit rd, bit wr, logic [AW-1:0] a, logic [31:0] d, int hold, bit inj, bit b2b);
      int n = cyc + 1;
      int t = 0;
      int start;
      bus.mar_addr  = a;
      bus.wdata     = d;
      bus.mdr_read  = rd;
      bus.ram_write = wr;
      bc = 0;
      model(rd, wr, a, d, n, inj);
      if (inj) begin
         step();
         chk("busy_rise", bus.busy, 1);
         bus.mdr_read  = 1'b0;
         bus.ram_write = 1'b0;
         step();
         bus.mar_addr = AW'($urandom);
         bus.wdata    = $urandom;
         bus.mdr_read = 1'b1;
         step();
         bus.mdr_read = 1'b0;
      end else begin
         for (int k = 0; k < hold; k++) begin
            step();
            if (k == 0) chk("busy_rise", bus.busy, 1);
         end
         bus.mdr_read  = 1'b0;
         bus.ram_write = 1'b0;
      end
      if (b2b) begin
         while (cyc < n + W + 1) @(negedge clk);
      end else begin
         start = cyc;
         while (bus.busy && t < 40) begin
            step();
            t++;
         end
         if (t >= 40) chk("idle_timeout", 1, 0);
         else begin
            chk("busy_len", bc, W + 2);
            if (start < n + W + 2) chk("busy_end", cyc, n + W + 2);
         end
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.mdr_read  = 1'b0;
      bus.ram_write = 1'b0;
      #1;
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_ready", bus.mem_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_overrun", bus.overrun, 0);
      last_rd = '0;
      ovr_m   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

   initial begin
      bit rd, wr, inj, b2b;
      int kind, hold;
      bus.mar_addr  = '0;
      bus.wdata     = '0;
      bus.mdr_read  = 1'b0;
      bus.ram_write = 1'b0;
      @(negedge clk);
      do_reset();
      for (int i = 0; i < DEPTH; i++) txn(1'b0, 1'b1, AW'(i), $urandom, $urandom_range(1, 3), 1'b0, 1'b0);
      txn(1'b0, 1'b1, 9'h055, 32'h0000_00AB, 3, 1'b0, 1'b0);
      txn(1'b1, 1'b0, 9'h055, 32'h0, 1, 1'b0, 1'b0);
      txn(1'b1, 1'b0, 9'h010, 32'h0, 10, 1'b0, 1'b0);
      // Reset one cycle into the wait of a write: the write must be abandoned.
      bus.mar_addr  = 9'h040;
      bus.wdata     = 32'hDEAD_BEEF;
      bus.ram_write = 1'b1;
      @(negedge clk);
      @(negedge clk);
      do_reset();
      txn(1'b1, 1'b0, 9'h040, 32'h0, 1, 1'b0, 1'b0);
      txn(1'b1, 1'b0, 9'h010, 32'h0, 1, 1'b1, 1'b0);
      txn(1'b1, 1'b1, 9'h030, 32'h1234_5678, 1, 1'b0, 1'b0);
      txn(1'b1, 1'b0, 9'h030, 32'h0, 2, 1'b0, 1'b0);
      txn(1'b1, 1'b0, 9'h1FF, 32'h0, 1, 1'b0, 1'b0);
      txn(1'b0, 1'b1, 9'h123, 32'hCAFE_0001, 1, 1'b0, 1'b1);
      txn(1'b1, 1'b0, 9'h023, 32'h0, 2, 1'b0, 1'b1);
      txn(1'b1, 1'b0, 9'h123, 32'h0, 1, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         if (i % 50 == 0) do_reset();
         kind = $urandom_range(0, 9);
         rd   = kind < 5 || kind == 9;
         wr   = kind >= 5;
         inj  = kind == 8;
         b2b  = (kind == 7 || kind == 2) && i % 50 != 49;
         hold = b2b ? $urandom_range(1, W) : $urandom_range(1, 4);
         txn(rd, wr, AW'($urandom_range(0, 511)), $urandom, hold, inj, b2b);
      end
      repeat (10) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
